// File: rtl/oct_counter.sv
// ---------------------------------------------------------------------------
// oct_counter: 3-bit modulo-8 up/down counter behind a debounced start/stop
// pushbutton. A button press toggles between IDLE and RUN. In RUN, a
// prescaler produces one count step every DIV clock cycles.
//
// Ports
//   clk      in   single rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   btn      in   raw pushbutton (asynchronous, bouncy, active-high)
//   up       in   direction: 1 = count up, 0 = count down
//   clr      in   synchronous clear of count/prescaler/wrap (state kept)
//   bin      out  current count 0..7 (registered)
//   running  out  high while in RUN (registered)
//   wrap     out  one-cycle pulse when bin shows 0 after 7 (up) or 7 after 0 (down)
// ---------------------------------------------------------------------------
module oct_counter #(
   parameter int unsigned DIV       = 50000000,
   parameter int unsigned DB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       up,
   input  logic       clr,
   output logic [2:0] bin,
   output logic       running,
   output logic       wrap
);

   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Synchronizer and debouncer registers
   logic            sync1_q, sync2_q;
   logic            db_q, db_d;
   logic            db_prev_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            db_rise_c;

   // FSM registers
   state_e          state_q, state_d;
   logic            running_q, running_d;

   // Datapath registers
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [2:0]       bin_q, bin_d;
   logic             wrap_q, wrap_d;
   logic             tick_c;

   // Two-flop synchronizer; nothing else ever looks at btn directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
      end
   end

   // Debouncer: accept a new level only after DB_CYCLES consecutive
   // cycles of disagreement; any return to agreement restarts the count.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      if (sync2_q != db_q) begin
         if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         db_cnt_q  <= '0;
      end else begin
         db_q      <= db_d;
         db_prev_q <= db_q;
         db_cnt_q  <= db_cnt_d;
      end
   end

   assign db_rise_c = db_q & ~db_prev_q;

   // FSM state register; running is registered alongside so it tracks state_q exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         running_q <= running_d;
      end
   end

   // FSM next-state: only a debounced press toggles the state.
   always_comb begin
      state_d = state_q;
      if (db_rise_c) begin
         state_d = (state_q == IDLE) ? RUN : IDLE;
      end
   end

   // FSM output decode, sampled into running_q on the same edge as the state.
   always_comb begin
      running_d = 1'b0;
      if (state_d == RUN) begin
         running_d = 1'b1;
      end
   end

   // Tick uses the current state, so a stop press on a tick edge still steps.
   assign tick_c = (state_q == RUN) && (pre_q == PRE_LAST);

   // Prescaler and count next-state; clr dominates a coincident tick.
   always_comb begin
      pre_d  = pre_q;
      bin_d  = bin_q;
      wrap_d = 1'b0;
      if (clr) begin
         pre_d = '0;
         bin_d = 3'd0;
      end else begin
         if (state_q != RUN || tick_c) begin
            pre_d = '0;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
         if (tick_c) begin
            if (up) begin
               bin_d  = bin_q + 3'd1;
               wrap_d = (bin_q == 3'd7);
            end else begin
               bin_d  = bin_q - 3'd1;
               wrap_d = (bin_q == 3'd0);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q  <= '0;
         bin_q  <= 3'd0;
         wrap_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         bin_q  <= bin_d;
         wrap_q <= wrap_d;
      end
   end

   assign bin     = bin_q;
   assign running = running_q;
   assign wrap    = wrap_q;

endmodule
